// File: rtl/pad_input_conditioner.sv
// rtl/pad_input_conditioner.sv - input pad synchroniser, glitch filter, edge detector and event register
module pad_input_conditioner #(
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_WIDTH   = 8,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pad_in_i,
  input  logic                 filter_en_i,
  input  logic [CNT_WIDTH-1:0] filter_len_i,
  output logic                 pad_value_o,
  output logic                 rise_o,
  output logic                 fall_o,
  output logic                 event_valid_o,
  input  logic                 event_ready_i,
  output logic                 event_rise_o,
  output logic                 event_overflow_o,
  input  logic                 clr_overflow_i
);

  typedef enum logic {IDLE, COUNT} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  state_t                 state, next_state;
  logic [CNT_WIDTH-1:0]   cnt, next_cnt;
  logic                   next_value;
  logic                   edge_seen;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign edge_seen = rise_o | fall_o;

  // Plain shift-register synchroniser for the asynchronous pad value
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in_i};
    end
  end

  // Filter FSM state, stability counter, conditioned level and edge pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      pad_value_o <= RESET_VAL;
      rise_o      <= 1'b0;
      fall_o      <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= next_cnt;
      pad_value_o <= next_value;
      rise_o      <= next_value & ~pad_value_o;
      fall_o      <= ~next_value & pad_value_o;
    end
  end

  // Next level: bypass follows the synchroniser, filter needs a stable run of len+1 cycles
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_value = pad_value_o;
    if (!filter_en_i) begin
      next_state = IDLE;
      next_cnt   = '0;
      next_value = sync_out;
    end else begin
      case (state)
        IDLE: begin
          if (sync_out != pad_value_o) begin
            if (filter_len_i == '0) begin
              next_value = ~pad_value_o;
            end else begin
              next_cnt   = CNT_WIDTH'(1);
              next_state = COUNT;
            end
          end
        end
        COUNT: begin
          if (sync_out == pad_value_o) begin
            next_cnt   = '0;
            next_state = IDLE;
          end else if (cnt >= filter_len_i) begin
            // >= so a live lowering of the length below cnt toggles at once
            next_value = ~pad_value_o;
            next_cnt   = '0;
            next_state = IDLE;
          end else begin
            next_cnt = cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          next_cnt   = '0;
          next_state = IDLE;
        end
      endcase
    end
  end

  // One-entry event register: oldest event kept, lost edges set the sticky overflow
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      event_valid_o    <= 1'b0;
      event_rise_o     <= 1'b0;
      event_overflow_o <= 1'b0;
    end else begin
      if (edge_seen && (!event_valid_o || event_ready_i)) begin
        event_valid_o <= 1'b1;
        event_rise_o  <= rise_o;
      end else if (event_valid_o && event_ready_i) begin
        event_valid_o <= 1'b0;
      end
      if (edge_seen && event_valid_o && !event_ready_i) begin
        event_overflow_o <= 1'b1;
      end else if (clr_overflow_i) begin
        event_overflow_o <= 1'b0;
      end
    end
  end

endmodule
